// File: rtl/bsg_mem_2r1w_sync_client.sv
// Requester-side front end for a 2-read/1-write synchronous RAM: issues dual reads,
// forwards same-cycle writes, and absorbs one cycle of read latency plus response backpressure.
module bsg_mem_2r1w_sync_client #(
    parameter  int width_p       = 32,
    parameter  int els_p         = 32,
    localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,

    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic [addr_width_lp-1:0] req_addr0_i,
    input  logic [addr_width_lp-1:0] req_addr1_i,

    output logic                     resp_v_o,
    input  logic                     resp_ready_i,
    output logic [width_p-1:0]       resp_data0_o,
    output logic [width_p-1:0]       resp_data1_o,

    output logic                     mem_w_v_o,
    output logic [addr_width_lp-1:0] mem_w_addr_o,
    output logic [width_p-1:0]       mem_w_data_o,

    output logic                     mem_r0_v_o,
    output logic [addr_width_lp-1:0] mem_r0_addr_o,
    input  logic [width_p-1:0]       mem_r0_data_i,

    output logic                     mem_r1_v_o,
    output logic [addr_width_lp-1:0] mem_r1_addr_o,
    input  logic [width_p-1:0]       mem_r1_data_i
);

    // PEND: RAM/bypass data presents this cycle; HOLD: data parked in hold registers.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e               state_r, state_n;
    logic                 pend_r, hold_r;
    logic                 accept;
    logic                 coll0, coll1;
    logic                 byp0_r, byp1_r;
    logic [width_p-1:0]   byp_data0_r, byp_data1_r;
    logic [width_p-1:0]   hold0_r, hold1_r;
    logic [width_p-1:0]   mux_data0, mux_data1;

    assign pend_r = (state_r == ST_PEND);
    assign hold_r = (state_r == ST_HOLD);

    assign accept = req_v_i & req_ready_o;
    assign coll0  = w_v_i & (w_addr_i == req_addr0_i);
    assign coll1  = w_v_i & (w_addr_i == req_addr1_i);

    // Write port is a straight pass-through; only the valid is gated by reset.
    assign mem_w_v_o    = w_v_i & reset_n_i;
    assign mem_w_addr_o = w_addr_i;
    assign mem_w_data_o = w_data_i;

    assign mem_r0_addr_o = req_addr0_i;
    assign mem_r1_addr_o = req_addr1_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n = state_r;
        if (accept) begin
            state_n = ST_PEND;
        end else if ((pend_r | hold_r) & ~resp_ready_i) begin
            state_n = ST_HOLD;
        end else begin
            state_n = ST_IDLE;
        end
    end

    always_comb begin
        resp_v_o    = pend_r | hold_r;
        req_ready_o = reset_n_i & ~hold_r & (~pend_r | resp_ready_i);
        mem_r0_v_o  = accept & ~coll0;
        mem_r1_v_o  = accept & ~coll1;
    end

    // Bypass flags choose forwarded write data over the (suppressed) RAM read.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            byp0_r <= 1'b0;
            byp1_r <= 1'b0;
        end else if (accept) begin
            byp0_r <= coll0;
            byp1_r <= coll1;
        end
    end

    // NOTE: data-only registers carry no reset; the control flags above qualify them.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (coll0) byp_data0_r <= w_data_i;
            if (coll1) byp_data1_r <= w_data_i;
        end
        if (pend_r & ~resp_ready_i) begin
            hold0_r <= mux_data0;
            hold1_r <= mux_data1;
        end
    end

    always_comb begin
        mux_data0 = byp0_r ? byp_data0_r : mem_r0_data_i;
        mux_data1 = byp1_r ? byp_data1_r : mem_r1_data_i;
        resp_data0_o = hold_r ? hold0_r : mux_data0;
        resp_data1_o = hold_r ? hold1_r : mux_data1;
    end

endmodule
